ascon_perm_sequencer: RTL and testbench

Sequences the Ascon permutation datapath for one operation at a time. It accepts the 3-bit `operation_mode` and `operation_ready` strobe from the SPI subnode, drives per-round enables and round-constant indices into the permutation round unit, and issues the state-load and key-XOR strobes. For the finalization operation it writes the tag back to 128-bit register 2. It returns `operation_done` so the SPI subnode can clear `operation_ready`.

---
 rtl/ascon_perm_sequencer_if.sv | 34 +++
 rtl/ascon_perm_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_ascon_perm_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ascon_perm_sequencer_if.sv
// Handshake and datapath-control bundle between the SPI subnode/datapath
// (master side) and the Ascon permutation sequencer (slave side).
interface ascon_perm_sequencer_if;
  // Request side, driven by the SPI subnode
  logic       operation_ready;
  logic [2:0] operation_mode;
  logic       pause;

  // Datapath control, driven by the sequencer
  logic       perm_load;
  logic       perm_round_en;
  logic [3:0] perm_round_idx;
  logic       key_xor_hi;
  logic       key_xor_lo;
  logic       reg_128b_wrback_en;
  logic [1:0] reg_128b_wrback_sel;

  // Status back to the SPI subnode
  logic       operation_done;
  logic       busy;
  logic       error;

  modport master (
    output operation_ready, operation_mode, pause,
    input  perm_load, perm_round_en, perm_round_idx, key_xor_hi, key_xor_lo,
           reg_128b_wrback_en, reg_128b_wrback_sel, operation_done, busy, error
  );

  modport slave (
    input  operation_ready, operation_mode, pause,
    output perm_load, perm_round_en, perm_round_idx, key_xor_hi, key_xor_lo,
           reg_128b_wrback_en, reg_128b_wrback_sel, operation_done, busy, error
  );
endinterface

// File: rtl/ascon_perm_sequencer.sv
// Ascon permutation sequencer: runs one operation (NOP, P12, P8, P6, INIT,
// FINAL) at a time, driving per-round enables, round-constant indices and the
// load / key-XOR / tag-writeback strobes of the permutation datapath.
// All outputs come straight from flops; a pause sampled on an edge holds the
// sequence position and blanks the strobes for the following cycle.
module ascon_perm_sequencer #(
  parameter int unsigned FIRST_IDX_P12 = 0,
  parameter int unsigned FIRST_IDX_P8  = 4,
  parameter int unsigned FIRST_IDX_P6  = 6,
  parameter int unsigned LAST_IDX      = 11
) (
  input  logic                   clk,
  input  logic                   rst,
  ascon_perm_sequencer_if.slave  bus
);

  localparam logic [3:0] IDX_P12  = 4'(FIRST_IDX_P12);
  localparam logic [3:0] IDX_P8   = 4'(FIRST_IDX_P8);
  localparam logic [3:0] IDX_P6   = 4'(FIRST_IDX_P6);
  localparam logic [3:0] IDX_LAST = 4'(LAST_IDX);
  localparam logic [1:0] TAG_REG  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_KXH, S_ROUND, S_KXL, S_WRBK, S_DONE
  } state_t;

  typedef enum logic [2:0] {
    M_NOP   = 3'd0,
    M_P12   = 3'd1,
    M_P8    = 3'd2,
    M_P6    = 3'd3,
    M_INIT  = 3'd4,
    M_FINAL = 3'd5,
    M_RSV6  = 3'd6,
    M_RSV7  = 3'd7
  } mode_t;

  state_t     state_q, state_d;
  mode_t      mode_q, mode_d;
  logic [3:0] round_cnt, round_cnt_d;
  logic       error_q, error_d;
  logic       stall;

  logic       perm_load_q;
  logic       perm_round_en_q;
  logic       key_xor_hi_q;
  logic       key_xor_lo_q;
  logic       wrback_en_q;
  logic [1:0] wrback_sel_q;
  logic       done_q;
  logic       busy_q;

  logic       round_last;
  // Counts 12..15 cannot be reached, but if present they end the round loop.
  assign round_last = (round_cnt >= IDX_LAST);

  // Next-state logic: start decode in IDLE, round walk, pause hold.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_d     = state_q;
    mode_d      = mode_q;
    round_cnt_d = round_cnt;
    error_d     = error_q;
    stall       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.operation_ready) begin
          mode_d      = mode_t'(bus.operation_mode);
          error_d     = 1'b0;
          round_cnt_d = 4'd0;
          unique case (mode_t'(bus.operation_mode))
            M_NOP:   state_d = S_DONE;
            M_P12: begin
              state_d     = S_ROUND;
              round_cnt_d = IDX_P12;
            end
            M_P8: begin
              state_d     = S_ROUND;
              round_cnt_d = IDX_P8;
            end
            M_P6: begin
              state_d     = S_ROUND;
              round_cnt_d = IDX_P6;
            end
            M_INIT:  state_d = S_LOAD;
            M_FINAL: state_d = S_KXH;
            M_RSV6, M_RSV7: begin
              state_d = S_DONE;
              error_d = 1'b1;
            end
            default: state_d = S_DONE;
          endcase
        end
      end

      S_LOAD, S_KXH: begin
        if (bus.pause) begin
          stall = 1'b1;
        end else begin
          state_d     = S_ROUND;
          round_cnt_d = 4'd0;
        end
      end

      S_ROUND: begin
        if (bus.pause) begin
          stall = 1'b1;
        end else if (!round_last) begin
          round_cnt_d = round_cnt + 4'd1;
        end else if (mode_q == M_INIT || mode_q == M_FINAL) begin
          state_d = S_KXL;
        end else begin
          state_d = S_DONE;
        end
      end

      S_KXL: begin
        if (bus.pause) begin
          stall = 1'b1;
        end else if (mode_q == M_FINAL) begin
          state_d = S_WRBK;
        end else begin
          state_d = S_DONE;
        end
      end

      S_WRBK: begin
        if (bus.pause) begin
          stall = 1'b1;
        end else begin
          state_d = S_DONE;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer registers: state, counters and the registered decode of the
  // state being entered (blanked while the current position is held).
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q         <= S_IDLE;
      mode_q          <= M_NOP;
      round_cnt       <= 4'd0;
      error_q         <= 1'b0;
      perm_load_q     <= 1'b0;
      perm_round_en_q <= 1'b0;
      key_xor_hi_q    <= 1'b0;
      key_xor_lo_q    <= 1'b0;
      wrback_en_q     <= 1'b0;
      wrback_sel_q    <= 2'b00;
      done_q          <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      mode_q          <= mode_d;
      round_cnt       <= round_cnt_d;
      error_q         <= error_d;
      perm_load_q     <= !stall && (state_d == S_LOAD);
      perm_round_en_q <= !stall && (state_d == S_ROUND);
      key_xor_hi_q    <= !stall && (state_d == S_KXH);
      key_xor_lo_q    <= !stall && (state_d == S_KXL);
      wrback_en_q     <= !stall && (state_d == S_WRBK);
      wrback_sel_q    <= (!stall && (state_d == S_WRBK)) ? TAG_REG : 2'b00;
      done_q          <= !stall && (state_d == S_DONE);
      busy_q          <= (state_d != S_IDLE);
    end
  end

  assign bus.perm_load           = perm_load_q;
  assign bus.perm_round_en       = perm_round_en_q;
  assign bus.perm_round_idx      = round_cnt;
  assign bus.key_xor_hi          = key_xor_hi_q;
  assign bus.key_xor_lo          = key_xor_lo_q;
  assign bus.reg_128b_wrback_en  = wrback_en_q;
  assign bus.reg_128b_wrback_sel = wrback_sel_q;
  assign bus.operation_done      = done_q;
  assign bus.busy                = busy_q;
  assign bus.error               = error_q;

endmodule

// File: tb/tb_ascon_perm_sequencer.sv
// Self-checking bench for ascon_perm_sequencer. A reference model expands each
// operation into its list of datapath actions and inserts one idle gap per
// sampled pause cycle; the DUT outputs are compared cycle by cycle.
module tb_ascon_perm_sequencer;

  logic clk = 1'b0;
  logic rst;

  ascon_perm_sequencer_if bus ();

  ascon_perm_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef enum {A_LOAD, A_KXH, A_ROUND, A_KXL, A_WRBK, A_DONE, A_GAP} kind_t;
  typedef struct {
    kind_t      kind;
    logic [3:0] idx;
  } act_t;

  act_t exp_q[$];

  // Expected action list of one operation, straight from the mode table.
  function automatic void build_ops(input logic [2:0] m);
    int first;
    exp_q.delete();
    case (m)
      3'd1:       first = 0;
      3'd2:       first = 4;
      3'd3:       first = 6;
      3'd4, 3'd5: first = 0;
      default:    first = -1;
    endcase
    if (m == 3'd4) exp_q.push_back('{A_LOAD, 4'd0});
    if (m == 3'd5) exp_q.push_back('{A_KXH, 4'd0});
    if (first >= 0)
      for (int i = first; i <= 11; i++) exp_q.push_back('{A_ROUND, 4'(i)});
    if (m == 3'd4 || m == 3'd5) exp_q.push_back('{A_KXL, 4'd0});
    if (m == 3'd5) exp_q.push_back('{A_WRBK, 4'd0});
    exp_q.push_back('{A_DONE, 4'd0});
  endfunction

  // Done latency (cycles after the start cycle) with no pause.
  function automatic int base_lat(input logic [2:0] m);
    case (m)
      3'd1:    return 13;
      3'd2:    return 9;
      3'd3:    return 7;
      3'd4:    return 15;
      3'd5:    return 16;
      default: return 1;
    endcase
  endfunction

  // {load, kxh, round_en, kxl, wrbk_en, wrbk_sel[1:0], done, busy}
  function automatic logic [8:0] vec_of(input act_t a);
    logic [8:0] v;
    v = 9'b0_0000_00_0_1;
    case (a.kind)
      A_LOAD:  v[8] = 1'b1;
      A_KXH:   v[7] = 1'b1;
      A_ROUND: v[6] = 1'b1;
      A_KXL:   v[5] = 1'b1;
      A_WRBK:  begin v[4] = 1'b1; v[3:2] = 2'b10; end
      A_DONE:  v[1] = 1'b1;
      default: v[0] = 1'b1;
    endcase
    return v;
  endfunction

  function automatic logic [8:0] obs_vec();
    return {bus.perm_load, bus.key_xor_hi, bus.perm_round_en, bus.key_xor_lo,
            bus.reg_128b_wrback_en, bus.reg_128b_wrback_sel,
            bus.operation_done, bus.busy};
  endfunction

  // Runs one operation from an IDLE cycle and checks every cycle through the
  // IDLE cycle that follows DONE. Caller's time is inside that IDLE cycle.
  task automatic run_op(input string tag, input logic [2:0] mode,
                        input int pause_at, input int pause_len,
                        input bit rand_pause, input bit keep_ready,
                        output int done_cycle);
    act_t       cur;
    bit         paused;
    bit         in_round;
    bit         exp_err;
    int         gaps;
    logic [8:0] ov;
    build_ops(mode);
    exp_err    = (mode >= 3'd6);
    gaps       = 0;
    in_round   = 1'b0;
    done_cycle = -1;
    bus.operation_ready = 1'b1;
    bus.operation_mode  = mode;
    bus.pause           = 1'($urandom_range(0, 1));  // ignored in IDLE
    @(posedge clk);
    cur = exp_q.pop_front();
    for (int k = 1; k <= 80; k++) begin
      #1;
      paused = rand_pause ? ($urandom_range(0, 3) == 0)
                          : (k >= pause_at && k < pause_at + pause_len);
      if (cur.kind == A_DONE) paused = 1'($urandom_range(0, 1));
      bus.pause          = paused;
      bus.operation_mode = 3'($urandom);
      if (!keep_ready) bus.operation_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      ov = obs_vec();
      n_checks++;
      if (ov !== vec_of(cur)) begin
        n_fail++;
        $display("FAIL %s cycle %0d outputs: got %b want %b", tag, k, ov, vec_of(cur));
      end
      if (cur.kind == A_ROUND || (cur.kind == A_GAP && in_round)) begin
        n_checks++;
        if (bus.perm_round_idx !== cur.idx) begin
          n_fail++;
          $display("FAIL %s cycle %0d round_idx: got %0d want %0d", tag, k,
                   bus.perm_round_idx, cur.idx);
        end
      end
      n_checks++;
      if (bus.error !== exp_err) begin
        n_fail++;
        $display("FAIL %s cycle %0d error: got %b want %b", tag, k, bus.error, exp_err);
      end
      if (cur.kind == A_DONE) begin
        done_cycle = k;
        break;
      end
      @(posedge clk);
      if (paused) begin
        gaps++;
        if (cur.kind != A_GAP) begin
          in_round = (cur.kind == A_ROUND);
          cur.kind = A_GAP;
        end
      end else begin
        cur = exp_q.pop_front();
      end
    end
    n_checks++;
    if (done_cycle != base_lat(mode) + gaps) begin
      n_fail++;
      $display("FAIL %s done_latency: got %0d want %0d", tag, done_cycle,
               base_lat(mode) + gaps);
    end
    if (done_cycle < 0) return;
    // IDLE cycle after DONE: everything low, error held.
    @(posedge clk);
    #1;
    if (!keep_ready) bus.operation_ready = 1'b0;
    bus.pause = 1'($urandom_range(0, 1));
    @(negedge clk);
    ov = obs_vec();
    n_checks++;
    if (ov !== 9'd0 || bus.error !== exp_err) begin
      n_fail++;
      $display("FAIL %s idle_after_done: got %b err %b want 000000000 err %b",
               tag, ov, bus.error, exp_err);
    end
  endtask

  task automatic test_reset();
    bus.operation_ready = 1'b0;
    bus.operation_mode  = 3'd0;
    bus.pause           = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obs_vec() !== 9'd0 || bus.error !== 1'b0 || bus.perm_round_idx !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %b err %b idx %0d want all zero",
               obs_vec(), bus.error, bus.perm_round_idx);
    end
  endtask

  task automatic test_p12();
    int dc;
    run_op("p12", 3'd1, 0, 0, 1'b0, 1'b0, dc);
    n_checks++;
    if (dc != 13) begin
      n_fail++;
      $display("FAIL p12_done_cycle: got %0d want 13", dc);
    end
  endtask

  task automatic test_p8_p6();
    int dc;
    run_op("p8", 3'd2, 0, 0, 1'b0, 1'b0, dc);
    n_checks++;
    if (dc != 9) begin
      n_fail++;
      $display("FAIL p8_done_cycle: got %0d want 9", dc);
    end
    run_op("p6", 3'd3, 0, 0, 1'b0, 1'b0, dc);
    n_checks++;
    if (dc != 7) begin
      n_fail++;
      $display("FAIL p6_done_cycle: got %0d want 7", dc);
    end
  endtask

  task automatic test_final();
    int dc;
    run_op("final", 3'd5, 0, 0, 1'b0, 1'b0, dc);
    n_checks++;
    if (dc != 16) begin
      n_fail++;
      $display("FAIL final_done_cycle: got %0d want 16", dc);
    end
  endtask

  // INIT with pause sampled in the three cycles starting at round index 5.
  task automatic test_init_pause();
    int dc;
    run_op("init_pause", 3'd4, 7, 3, 1'b0, 1'b0, dc);
    n_checks++;
    if (dc != 18) begin
      n_fail++;
      $display("FAIL init_pause_done_cycle: got %0d want 18", dc);
    end
  endtask

  task automatic test_error();
    int dc;
    run_op("illegal7", 3'd7, 0, 0, 1'b0, 1'b0, dc);
    n_checks++;
    if (dc != 1) begin
      n_fail++;
      $display("FAIL illegal_done_cycle: got %0d want 1", dc);
    end
    run_op("nop_after_err", 3'd0, 0, 0, 1'b0, 1'b0, dc);
    n_checks++;
    if (dc != 1) begin
      n_fail++;
      $display("FAIL nop_done_cycle: got %0d want 1", dc);
    end
  endtask

  // Reset at round index 7 of P12 with ready held: no done, clean restart.
  task automatic test_reset_midop();
    int dc;
    bus.operation_ready = 1'b1;
    bus.operation_mode  = 3'd1;
    bus.pause           = 1'b0;
    @(posedge clk);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus.perm_round_en !== 1'b1 || bus.perm_round_idx !== 4'(k - 1)) begin
        n_fail++;
        $display("FAIL midop_round cycle %0d: got en %b idx %0d want en 1 idx %0d",
                 k, bus.perm_round_en, bus.perm_round_idx, k - 1);
      end
      if (k < 8) @(posedge clk);
    end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obs_vec() !== 9'd0 || bus.error !== 1'b0) begin
      n_fail++;
      $display("FAIL midop_reset_state: got %b err %b want all zero", obs_vec(), bus.error);
    end
    run_op("restart_p12", 3'd1, 0, 0, 1'b0, 1'b0, dc);
  endtask

  // Random modes chained with ready held high and random pause cycles.
  task automatic test_back_to_back();
    int dc;
    for (int n = 0; n < 24; n++) begin
      run_op($sformatf("b2b%0d", n), 3'($urandom_range(0, 7)), 0, 0, 1'b1, 1'b1, dc);
    end
    bus.operation_ready = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bus.operation_ready = 1'b0;
    bus.operation_mode  = 3'd0;
    bus.pause           = 1'b0;
    test_reset();
    test_p12();
    test_p8_p6();
    test_final();
    test_init_pause();
    test_error();
    test_reset_midop();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
